// File: rtl/mips32_pkg.sv
// mips32_pkg: shared widths, arbiter states and requester IDs for the MIPS32 memory arbiter
package mips32_pkg;
  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;
  typedef enum logic [1:0] {RUN, DRAIN, STOPPED} arb_state_t;
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D = 1'b1;
endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// mips32_mem_arbiter_if: fetch, data and memory-array signals shared by the arbiter
interface mips32_mem_arbiter_if #(parameter int AW = mips32_pkg::DEF_AW, parameter int DW = mips32_pkg::DEF_DW);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one single-port memory between fetch and load/store with bounded fetch starvation
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic halted,
  output logic busy,
  mips32_mem_arbiter_if.slave bus
);
  arb_state_t state, state_nxt;
  logic [3:0] starv_cnt;
  logic rsp_valid, rsp_id, rsp_we;
  logic fetch_win, data_win, fetch_pend;
  // rst_n gates grants so every command output drops the moment reset asserts
  always_comb begin
    fetch_win = rst_n && bus.if_req && state == RUN && !halted && (!bus.d_req || starv_cnt == 4'(MAX_WAIT));
    data_win = rst_n && bus.d_req && !fetch_win;
    fetch_pend = rsp_valid && rsp_id == REQ_IF;
    state_nxt = (state == RUN && halted) ? (fetch_pend ? DRAIN : STOPPED) :
                (state == DRAIN && !fetch_pend) ? STOPPED : state;
  end
  assign bus.if_gnt = fetch_win;
  assign bus.d_gnt = data_win;
  assign bus.mem_en = fetch_win || data_win;
  assign bus.mem_we = data_win && bus.d_we;
  assign bus.mem_addr = fetch_win ? bus.if_addr : data_win ? bus.d_addr : {AW{1'b0}};
  assign bus.mem_wdata = (data_win && bus.d_we) ? bus.d_wdata : {DW{1'b0}};
  assign bus.if_rvalid = rsp_valid && rsp_id == REQ_IF;
  assign bus.d_rvalid = rsp_valid && rsp_id == REQ_D;
  assign bus.if_rdata = bus.if_rvalid ? bus.mem_rdata : {DW{1'b0}};
  assign bus.d_rdata = (bus.d_rvalid && !rsp_we) ? bus.mem_rdata : {DW{1'b0}};
  assign busy = rsp_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      starv_cnt <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_id <= REQ_IF;
      rsp_we <= 1'b0;
    end else begin
      state <= state_nxt;
      starv_cnt <= (!bus.if_req || fetch_win) ? 4'd0 : (starv_cnt == 4'(MAX_WAIT)) ? starv_cnt : starv_cnt + 4'd1;
      rsp_valid <= fetch_win || data_win;
      rsp_id <= fetch_win ? REQ_IF : REQ_D;
      rsp_we <= data_win && bus.d_we;
    end
  end
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: directed checks of arbitration, starvation, halt and reset behaviour
module tb_mips32_mem_arbiter;
  import mips32_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted = 1'b0;
  logic busy;
  int total = 0;
  int bad = 0;
  logic [31:0] mem [0:1023];
  mips32_mem_arbiter_if #(.AW(10), .DW(32)) bus ();
  mips32_mem_arbiter #(.AW(10), .DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted), .busy(busy), .bus(bus)
  );
  always #5 clk = ~clk;
  // synchronous-read memory array, write-through visible on the next access
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end
  task automatic test_reset();
    #1;
    total++;
    if ({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy} !== 113'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy});
    end
    total++;
    if (dut.state !== RUN || dut.starv_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_state got=%0d/%0d exp=%0d/0", dut.state, dut.starv_cnt, RUN);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask
  task automatic test_fetch_only();
    @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 10'd0; #1;
    total++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {4'b1010, 10'd0}) begin
      bad++; $display("FAIL fetch_grant got=%b exp=%b", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr}, {4'b1010, 10'd0});
    end
    @(negedge clk); bus.if_req = 1'b0; #1;
    total++;
    if ({bus.if_rvalid, bus.d_rvalid, busy, bus.if_rdata} !== {3'b101, 32'h280a00c8}) begin
      bad++; $display("FAIL fetch_rsp got=%b/%h exp=101/280a00c8", {bus.if_rvalid, bus.d_rvalid, busy}, bus.if_rdata);
    end
  endtask
  task automatic test_conflict();
    @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd200; bus.if_req = 1'b1; bus.if_addr = 10'd5; #1;
    total++;
    if ({bus.d_gnt, bus.if_gnt, bus.mem_addr} !== {2'b10, 10'd200}) begin
      bad++; $display("FAIL conflict_data_first got=%b/%0d exp=10/200", {bus.d_gnt, bus.if_gnt}, bus.mem_addr);
    end
    @(negedge clk); bus.d_req = 1'b0; #1;
    total++;
    if ({bus.d_rvalid, bus.if_rvalid, bus.d_rdata} !== {2'b10, 32'd7}) begin
      bad++; $display("FAIL conflict_load_rsp got=%b/%h exp=10/7", {bus.d_rvalid, bus.if_rvalid}, bus.d_rdata);
    end
    total++;
    if ({bus.if_gnt, bus.mem_addr} !== {1'b1, 10'd5}) begin
      bad++; $display("FAIL conflict_fetch_next got=%b/%0d exp=1/5", bus.if_gnt, bus.mem_addr);
    end
    @(negedge clk); bus.if_req = 1'b0; #1;
    total++;
    if ({bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata} !== {2'b10, 32'ha0000005, 32'd0}) begin
      bad++; $display("FAIL conflict_fetch_rsp got=%b/%h/%h exp=10/a0000005/0", {bus.if_rvalid, bus.d_rvalid}, bus.if_rdata, bus.d_rdata);
    end
  endtask
  task automatic test_starvation();
    logic exp_if [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 10'd10; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd20; #1;
      total++;
      if ({bus.if_gnt, bus.d_gnt} !== {exp_if[i], !exp_if[i]}) begin
        bad++; $display("FAIL starve_cycle%0d got=%b exp=%b", i, {bus.if_gnt, bus.d_gnt}, {exp_if[i], !exp_if[i]});
      end
    end
    @(negedge clk); bus.if_req = 1'b0; bus.d_req = 1'b0; #1;
    total++;
    if ({bus.d_rvalid, bus.if_rvalid, bus.d_rdata} !== {2'b10, 32'ha0000014}) begin
      bad++; $display("FAIL starve_last_rsp got=%b/%h exp=10/a0000014", {bus.d_rvalid, bus.if_rvalid}, bus.d_rdata);
    end
  endtask
  task automatic test_store_load();
    @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'd198; bus.d_wdata = 32'd5040; #1;
    total++;
    if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b111, 10'd198, 32'd5040}) begin
      bad++; $display("FAIL store_cmd got=%b/%0d/%0d exp=111/198/5040", {bus.d_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk); bus.d_we = 1'b0; #1;
    total++;
    if ({bus.d_rvalid, bus.d_rdata, bus.mem_we, bus.mem_wdata} !== {1'b1, 32'd0, 1'b0, 32'd0}) begin
      bad++; $display("FAIL store_rsp got=%b/%h/%b/%h exp=1/0/0/0", bus.d_rvalid, bus.d_rdata, bus.mem_we, bus.mem_wdata);
    end
    @(negedge clk); bus.d_req = 1'b0; #1;
    total++;
    if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'd5040}) begin
      bad++; $display("FAIL load_after_store got=%b/%0d exp=1/5040", bus.d_rvalid, bus.d_rdata);
    end
  endtask
  task automatic test_halt();
    @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 10'd1; #1;
    total++;
    if (bus.if_gnt !== 1'b1) begin
      bad++; $display("FAIL halt_pre_fetch got=%b exp=1", bus.if_gnt);
    end
    @(negedge clk); halted = 1'b1; bus.if_addr = 10'd2; bus.d_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'd300; bus.d_wdata = 32'h55; end
      if (i == 3) begin bus.d_we = 1'b0; halted = 1'b0; end
      if (i != 0) @(negedge clk);
      #1;
      total++;
      if ({bus.if_gnt, bus.d_gnt} !== {1'b0, i >= 2}) begin
        bad++; $display("FAIL halt_block%0d got=%b exp=%b", i, {bus.if_gnt, bus.d_gnt}, {1'b0, i >= 2});
      end
    end
    total++;
    if (dut.state !== STOPPED) begin
      bad++; $display("FAIL halt_stopped got=%0d exp=%0d", dut.state, STOPPED);
    end
    @(negedge clk); bus.d_req = 1'b0; #1;
    total++;
    if ({bus.d_rvalid, bus.d_rdata, bus.if_gnt} !== {1'b1, 32'h55, 1'b0}) begin
      bad++; $display("FAIL halt_load_store got=%b/%h/%b exp=1/55/0", bus.d_rvalid, bus.d_rdata, bus.if_gnt);
    end
  endtask
  task automatic test_drain();
    total++;
    if (dut.state !== STOPPED) begin
      bad++; $display("FAIL drain_still_stopped got=%0d exp=%0d", dut.state, STOPPED);
    end
    @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1;
    @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 10'd3; #1;
    total++;
    if (bus.if_gnt !== 1'b1) begin
      bad++; $display("FAIL drain_fetch got=%b exp=1", bus.if_gnt);
    end
    @(negedge clk); halted = 1'b1; bus.if_addr = 10'd4; #1;
    total++;
    if ({bus.if_rvalid, bus.if_rdata, bus.if_gnt} !== {1'b1, 32'ha0000003, 1'b0}) begin
      bad++; $display("FAIL drain_rsp got=%b/%h/%b exp=1/a0000003/0", bus.if_rvalid, bus.if_rdata, bus.if_gnt);
    end
    @(negedge clk); #1;
    total++;
    if ({dut.state, bus.if_gnt} !== {DRAIN, 1'b0}) begin
      bad++; $display("FAIL drain_state got=%0d/%b exp=%0d/0", dut.state, bus.if_gnt, DRAIN);
    end
    @(negedge clk); #1;
    total++;
    if (dut.state !== STOPPED) begin
      bad++; $display("FAIL drain_to_stopped got=%0d exp=%0d", dut.state, STOPPED);
    end
    halted = 1'b0; bus.if_req = 1'b0;
  endtask
  task automatic test_reset_mid();
    @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'd200; #1;
    total++;
    if (bus.d_gnt !== 1'b1) begin
      bad++; $display("FAIL rstmid_grant got=%b exp=1", bus.d_gnt);
    end
    @(negedge clk); rst_n = 1'b0; bus.if_req = 1'b1; #1;
    total++;
    if ({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy} !== 113'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%h exp=0", {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy});
    end
    @(negedge clk); rst_n = 1'b1; bus.d_req = 1'b0; bus.if_req = 1'b0; #1;
    total++;
    if ({bus.if_rvalid, bus.d_rvalid, busy} !== 3'b000 || dut.state !== RUN) begin
      bad++; $display("FAIL rstmid_release got=%b/%0d exp=000/%0d", {bus.if_rvalid, bus.d_rvalid, busy}, dut.state, RUN);
    end
    @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 10'd0; #1;
    total++;
    if (bus.if_gnt !== 1'b1) begin
      bad++; $display("FAIL rstmid_fetch got=%b exp=1", bus.if_gnt);
    end
    @(negedge clk); bus.if_req = 1'b0; #1;
    total++;
    if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h280a00c8}) begin
      bad++; $display("FAIL rstmid_fetch_rsp got=%b/%h exp=1/280a00c8", bus.if_rvalid, bus.if_rdata);
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'ha0000000 | i;
    mem[0] = 32'h280a00c8;
    mem[200] = 32'd7;
    bus.mem_rdata = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    test_reset();
    test_fetch_only();
    test_conflict();
    test_starvation();
    test_store_load();
    test_halt();
    test_drain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

Single-clock arbiter that shares the unified single-port instruction/data memory of the pipelined MIPS32 core between two requesters: the IF-stage fetch port and the MEM-stage load/store port. It sits between the pipeline stages and the memory array. It issues at most one memory command per cycle and returns read data one cycle later. It enforces a bounded fetch-starvation limit and freezes instruction fetch once the core halts.

## Interface
- `AW`, 10: word-address width.
- `DW`, 32: data width.
- `MAX_WAIT`, 4: number of consecutive lost fetch cycles before fetch wins the next conflict. Legal range is 1..15.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` until granted.
- `if_addr`  in  AW  fetch word address.
- `if_gnt`  out  1  fetch command issued this cycle.
- `if_rvalid`  out  1  fetch data valid, one cycle after `if_gnt`.
- `if_rdata`  out  DW  fetched instruction.
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` until granted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data word address.
- `d_wdata`  in  DW  store data.
- `d_gnt`  out  1  data command issued this cycle.
- `d_rvalid`  out  1  pulses one cycle after every `d_gnt`.
- `d_rdata`  out  DW  load data; 0 for stores.
- `halted`  in  1  core has retired HLT (level).
- `mem_en`  out  1  memory access enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data; synchronous, 1-cycle latency.
- `busy`  out  1  a response is outstanding (response register valid).

## Operation
- FSM states:
  - RUN (reset state): fetch and data are both eligible.
  - DRAIN: `halted` was seen while a fetch response is outstanding; fetch is blocked.
  - STOPPED: fetch is blocked permanently.
- FSM transitions:
  - RUN→STOPPED when `halted`=1 and no fetch response is pending.
  - RUN→DRAIN when `halted`=1 and a fetch response is pending.
  - DRAIN→STOPPED after that fetch response has been delivered.
  - STOPPED exits only on reset.
- Data requests are served in every state, so stores still in flight after HLT complete.
- Arbitration rules:
  - Only one requester active: it is granted.
  - Both active: data wins by default, because it is the older instruction.
  - Both active and `starv_cnt`==`MAX_WAIT`: fetch wins.
- Starvation counter `starv_cnt` (4 bits):
  - increments each cycle `if_req`=1 without `if_gnt`, saturating at `MAX_WAIT`;
  - clears on `if_gnt` or when `if_req`=0.
- On a grant, `mem_en`=1 and `mem_addr`/`mem_we`/`mem_wdata` are driven combinationally from the winner in the same cycle. `mem_we`=1 only for a data store.
- Response register captures the winner ID and `we`. Next cycle, exactly one of `if_rvalid`/`d_rvalid` pulses, with `mem_rdata` routed to the winner's data output (`d_rdata`=0 for stores). The non-selected rdata output reads 0.
- No address range check; addresses wrap modulo 2^AW.

## Timing
- Grant and memory command are issued in cycle N; rvalid and rdata are valid in cycle N+1. Back-to-back grants are allowed every cycle, giving throughput of 1 access/cycle.
- A requester may drop its request or change address only in the cycle after it sees its grant.
- A store in cycle N is visible to a load granted in cycle N+1.
- Reset values, all asynchronous on `rst_n`=0:
  - outputs: `if_gnt`, `if_rvalid`, `if_rdata`, `d_gnt`, `d_rvalid`, `d_rdata`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `busy` are all 0;
  - internal: state=RUN, `starv_cnt`=0, response register empty.
- Reset mid-access: any pending response is discarded and no rvalid pulses after release.
- `halted` and `if_req` in the same cycle: fetch is not granted that cycle, even if `starv_cnt` is saturated.

## Structure
- Shared package `mips32_pkg`:
  - default `AW`/`DW`;
  - arbiter state enum (RUN, DRAIN, STOPPED);
  - requester ID constants (REQ_IF, REQ_D).
- Flat module. The starvation counter and response register are small enough to inline; no sub-module.

## Test plan
- Fetch only: mem[0]=0x280a00c8, `if_req` with `if_addr`=0 → `if_gnt`=1 in the same cycle; next cycle `if_rvalid`=1 and `if_rdata`=0x280a00c8.
- Conflict: load `d_addr`=200 (mem=7) together with fetch `if_addr`=5 → `d_gnt` first and `d_rvalid` with `d_rdata`=7; `if_gnt` on the following cycle.
- Starvation with `MAX_WAIT`=4, both requests held continuously → data granted for 4 cycles, fetch granted on the 5th cycle, data granted again on the 6th.
- Store then load: store `d_addr`=198, `d_wdata`=5040 → `mem_we`=1; a load of 198 in the next cycle returns 5040.
- Halt: `halted`=1 while `if_req`=1 → no further `if_gnt` and state reaches STOPPED; a subsequent store is still granted; fetch stays blocked until `rst_n` pulses low.
- Reset mid-operation: `rst_n`=0 in the cycle after a grant → all outputs 0 immediately; no rvalid after release; first post-reset fetch is served normally.
